uart_rs232_rx: RTL and testbench
================================

Name: uart_rs232_rx

Overview:
- RS-232 UART receiver. It is the receive-side counterpart of the existing UART_rs232_tx.
- Decodes asynchronous serial frames on Rx: 1 start bit, NBits data bits LSB first, no parity, 1 stop bit.
- Uses the same 16x oversampling Tick as the transmitter.
- Delivers the received byte to FPGA logic with a one-cycle done strobe and a framing-error flag.

Parameters:
- OVERSAMPLE, 16, Tick pulses per bit period. Must be a power of two, 8 or more.
- SYNC_STAGES, 2, number of flip-flops in the Rx metastability synchroniser (2 or more).

Ports:
- Clk  input  1  system clock.
- Rst_n  input  1  reset: asynchronous, active-low.
- Tick  input  1  oversample enable, one Clk cycle wide, OVERSAMPLE times per bit. Synchronous to Clk.
- Rx  input  1  serial line, asynchronous, idles high.
- RxEn  input  1  receiver enable, level-sensitive.
- NBits  input  4  data bits per frame, legal range 5..8.
- RxData  output  8  received data, right-justified, upper bits zero when NBits<8.
- RxDone  output  1  one-Clk-cycle pulse when a frame completes.
- FrameErr  output  1  high if the last completed frame had stop bit = 0.

Behaviour:
- Reset values:
  - RxData = 0, RxDone = 0, FrameErr = 0.
  - State = IDLE, counters = 0.
  - Every synchroniser stage = 1, so no false start bit after reset.
- All logic is clocked on posedge Clk. Counters advance only in cycles where Tick = 1. There are no Tick-clocked processes.
- rx_s is the synchronised Rx. This adds SYNC_STAGES Clk cycles of latency, which is acceptable.
- IDLE:
  - On a Tick with RxEn = 1 and rx_s = 0: go to START, clear tick_cnt.
  - Latch NBits into nbits_q. Values 0 and 9..15 are treated as 8.
- START:
  - tick_cnt increments on each Tick.
  - At the Tick where tick_cnt = OVERSAMPLE/2-1 (mid start bit):
    - rx_s = 0: go to DATA, clear tick_cnt and bit_cnt.
    - rx_s = 1: glitch; return to IDLE with no outputs.
- DATA:
  - At the Tick where tick_cnt = OVERSAMPLE-1 (the centre of each data bit): shift_q <= {rx_s, shift_q[7:1]}, bit_cnt++, tick_cnt wraps to 0.
  - After nbits_q bits: go to STOP.
- STOP, at the stop-bit centre (tick_cnt = OVERSAMPLE-1):
  - Always:
    - RxData <= shift_q >> (8 - nbits_q).
    - RxDone = 1 for exactly the next Clk cycle.
    - FrameErr <= ~rx_s.
  - rx_s = 1: go to IDLE.
  - rx_s = 0: go to WAIT_HIGH.
- WAIT_HIGH (break or framing error): stay until rx_s = 1, then go to IDLE. Prevents a held-low line retriggering a start.
- Timing:
  - RxDone rises one Clk cycle after the Tick that samples the stop-bit centre.
  - That is about 9.5 bit periods after the falling edge of the start bit for 8N1.
  - Back-to-back frames, where the next start bit immediately follows the stop bit, are received without loss.
- Output holding: RxData and FrameErr hold until the next completed frame. There is no consumer handshake, so an unread byte is overwritten.
- RxEn deasserted in any non-IDLE state: abort to IDLE on the next Clk. No RxDone. RxData and FrameErr are unchanged.
- Rst_n asserted mid-frame: immediate return to reset values. The partial frame is discarded.
- Tick stalled: state is frozen. There is no timeout.
- NBits changing mid-frame has no effect, because nbits_q is latched at IDLE to START.
- Widths:
  - tick_cnt is log2(OVERSAMPLE) bits and wraps naturally.
  - bit_cnt is 4 bits.

Decomposition:
- Shared package uart_pkg, also used by the transmitter:
  - State encoding constants: IDLE, START, DATA, STOP, WAIT_HIGH.
  - OVERSAMPLE default.
  - NBITS_MIN = 5, NBITS_MAX = 8.
- One sub-module, uart_sync: an SYNC_STAGES-deep flip-flop chain with reset value 1. It is reusable for other asynchronous inputs such as TxEn.
- The FSM, counters and shift register stay in uart_rs232_rx.

Test Plan:
- Bench setup: Clk 50 MHz, Tick every 4 Clk cycles, so one bit is 64 Clk cycles.
- Cases 1 to 6 are sent on Rx. Each line gives stimulus -> required response.
1. NBits=8, RxEn=1, frame 0xA5 -> one RxDone pulse, RxData=0xA5, FrameErr=0, about 608 Clk cycles after the start edge.
2. NBits=7, frame 0x55 followed back-to-back by 0x2A -> two RxDone pulses, RxData=0x55 then 0x2A, upper bit 0.
3. Rx low for 4 Ticks then high (glitch) -> no RxDone; a valid 0x3C sent next is received correctly.
4. 0xFF with stop bit forced 0, line held low for 20 bit periods, then 0x81 -> first RxDone with FrameErr=1, no further RxDone while low; then RxDone with 0x81 and FrameErr=0.
5. RxEn dropped during data bit 3 of 0x96 -> no RxDone, RxData keeps its previous value. Re-enable, send 0x96 -> RxData=0x96.
6. Rst_n pulsed low during the stop bit of 0x12 -> no RxDone, outputs return to 0. The next frame 0x34 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the RS-232 UART receiver and transmitter.
//   uart_state_t   - frame FSM state encoding
//   OVERSAMPLE_DEF - default number of Tick pulses per bit period
//   NBITS_MIN/MAX  - legal range of data bits per frame
//   nbits_norm()   - maps out-of-range frame widths (0, 9..15) to NBITS_MAX
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_t;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int NBITS_MIN      = 5;
   localparam int NBITS_MAX      = 8;

   function automatic logic [3:0] nbits_norm(input logic [3:0] n);
      if (n == 4'd0 || n > 4'(NBITS_MAX))
         return 4'(NBITS_MAX);
      return n;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: STAGES-deep flip-flop chain bringing an asynchronous input into
// the clk domain. Resets to 1 so an idle-high line never looks active out of
// reset.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronised output, STAGES cycles behind d
module uart_sync
   import uart_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '1;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rs232_rx.sv
// uart_rs232_rx: RS-232 receiver, 1 start bit, NBits data bits LSB first,
// no parity, 1 stop bit, sampled with an OVERSAMPLE x Tick enable.
//   Clk      - system clock
//   Rst_n    - asynchronous active-low reset
//   Tick     - one-cycle oversample enable, OVERSAMPLE pulses per bit
//   Rx       - asynchronous serial line, idles high
//   RxEn     - receiver enable (level)
//   NBits    - data bits per frame (5..8; 0 and 9..15 act as 8)
//   RxData   - last received word, right-justified
//   RxDone   - one-cycle strobe when a frame completes
//   FrameErr - stop bit of the last completed frame was 0
module uart_rs232_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Tick,
   input  logic       Rx,
   input  logic       RxEn,
   input  logic [3:0] NBits,
   output logic [7:0] RxData,
   output logic       RxDone,
   output logic       FrameErr
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] MID_CNT = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] END_CNT = TW'(OVERSAMPLE - 1);

   if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_chk
      $error("OVERSAMPLE must be a power of two, 8 or more");
   end
   if (SYNC_STAGES < 2) begin : g_sync_chk
      $error("SYNC_STAGES must be 2 or more");
   end

   logic rx_s;

   uart_sync #(.STAGES(SYNC_STAGES)) u_rx_sync (
      .clk   (Clk),
      .rst_n (Rst_n),
      .d     (Rx),
      .q     (rx_s)
   );

   uart_state_t   state_q, state_d;
   logic [TW-1:0] tick_q,  tick_d;
   logic [3:0]    bit_q,   bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [3:0]    nbits_q, nbits_d;
   logic [7:0]    data_d;
   logic          ferr_d, done_d;
   logic [3:0]    rshift;

   // Data enters at bit 7 and moves down, so a short frame ends up in the
   // top nbits_q bits; shifting right by the unused count right-justifies it
   // and discards stale bits from earlier frames.
   assign rshift = 4'd8 - nbits_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      nbits_d = nbits_q;
      data_d  = RxData;
      ferr_d  = FrameErr;
      done_d  = 1'b0;

      if (state_q != IDLE && !RxEn) begin
         // Abort: partial frame dropped, visible outputs untouched.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (Tick && RxEn && !rx_s) begin
                  state_d = START;
                  tick_d  = '0;
                  nbits_d = nbits_norm(NBits);
               end
            end
            START: begin
               if (Tick) begin
                  if (tick_q == MID_CNT) begin
                     // Still low mid start bit: real start. High: glitch.
                     if (!rx_s) begin
                        state_d = DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end
            end
            DATA: begin
               if (Tick) begin
                  tick_d = tick_q + 1'b1;  // wraps to 0 after END_CNT
                  if (tick_q == END_CNT) begin
                     shift_d = {rx_s, shift_q[7:1]};
                     bit_d   = bit_q + 4'd1;
                     if (bit_q + 4'd1 == nbits_q)
                        state_d = STOP;
                  end
               end
            end
            STOP: begin
               if (Tick) begin
                  tick_d = tick_q + 1'b1;
                  if (tick_q == END_CNT) begin
                     data_d  = shift_q >> rshift;
                     done_d  = 1'b1;
                     ferr_d  = ~rx_s;
                     // A low stop bit may be a break; wait for the line to
                     // return high before hunting for the next start bit.
                     state_d = rx_s ? IDLE : WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         nbits_q  <= 4'(NBITS_MAX);
         RxData   <= '0;
         RxDone   <= 1'b0;
         FrameErr <= 1'b0;
      end else begin
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         nbits_q  <= nbits_d;
         RxData   <= data_d;
         RxDone   <= done_d;
         FrameErr <= ferr_d;
      end
   end

endmodule

// File: tb/tb_uart_rs232_rx.sv
// tb_uart_rs232_rx: self-checking bench for uart_rs232_rx. A frame-level
// model queues the word/flag each transmitted frame must produce; a monitor
// checks every RxDone against it and checks RxData/FrameErr hold every cycle.
module tb_uart_rs232_rx;
   import uart_pkg::*;

   localparam int BIT = 64;  // Clk cycles per bit (Tick every 4 Clk, 16x)

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       Tick = 1'b0;
   logic       Rx = 1'b1;
   logic       RxEn = 1'b0;
   logic [3:0] NBits = 4'd8;
   logic [7:0] RxData;
   logic       RxDone;
   logic       FrameErr;

   uart_rs232_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Tick     (Tick),
      .Rx       (Rx),
      .RxEn     (RxEn),
      .NBits    (NBits),
      .RxData   (RxData),
      .RxDone   (RxDone),
      .FrameErr (FrameErr)
   );

   always #10 Clk = ~Clk;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      int         t0;
      int         n;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] exp_data = 8'h00;
   logic       exp_ferr = 1'b0;
   int         cyc = 0;
   int         dones = 0;
   int         tests = 0;
   int         fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         if (fails <= 30)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         if (fails <= 30)
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
      end
   endtask

   // Cycle counter and Tick (one pulse every 4 Clk).
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge Clk);
         cyc++;
         #1;
         ph = (ph + 1) % 4;
         Tick = (ph == 0);
      end
   end

   // Monitor: every RxDone consumes one expected frame; the held outputs
   // must match the last expected frame on every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (RxDone) begin
            dones++;
            if (expq.size() == 0) begin
               chk("unexpected_rxdone", 32'd1, 32'd0);
            end else begin
               e = expq.pop_front();
               exp_data = e.data;
               exp_ferr = e.ferr;
               // Done lands about (n+1.5) bit periods after the start edge.
               chk_rng("done_latency", cyc - e.t0, e.n*BIT + 96, e.n*BIT + 108);
            end
         end
         chk("rxdata", {24'd0, RxData}, {24'd0, exp_data});
         chk("frameerr", {31'd0, FrameErr}, {31'd0, exp_ferr});
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   function automatic int neff(input logic [3:0] nb);
      return (nb == 4'd0 || nb > 4'd8) ? 8 : int'(nb);
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic bitp(input logic v, input int len);
      Rx = v;
      wait_clk(len);
   endtask

   task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic stop_v,
                       input bit nb_scramble);
      int   n;
      exp_t e;
      n = neff(nb);
      NBits = nb;
      e.data = d & 8'((1 << n) - 1);
      e.ferr = ~stop_v;
      e.t0   = cyc;
      e.n    = n;
      expq.push_back(e);
      bitp(1'b0, BIT);
      if (nb_scramble) NBits = 4'($urandom);  // latched width must win
      for (int i = 0; i < n; i++) bitp(d[i], BIT);
      bitp(stop_v, BIT);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (expq.size() != 0 && k < 3000) begin
         wait_clk(1);
         k++;
      end
      chk(name, expq.size(), 0);
      expq.delete();
   endtask

   initial begin
      int d0;
      logic [7:0] v;
      v = 8'h96;

      // Reset state
      wait_clk(5);
      chk("reset_rxdata", {24'd0, RxData}, 32'h0);
      chk("reset_rxdone", {31'd0, RxDone}, 32'h0);
      chk("reset_frameerr", {31'd0, FrameErr}, 32'h0);
      Rst_n = 1'b1;
      RxEn  = 1'b1;
      bitp(1'b1, 2*BIT);

      // 1: 8N1 0xA5
      d0 = dones;
      send(8'hA5, 4'd8, 1'b1, 1'b0);
      bitp(1'b1, BIT);
      drain("c1_drain");
      chk("c1_dones", dones - d0, 1);
      chk("c1_rxdata", {24'd0, RxData}, 32'hA5);
      chk("c1_frameerr", {31'd0, FrameErr}, 32'h0);

      // 2: 7-bit back-to-back 0x55, 0x2A
      d0 = dones;
      send(8'h55, 4'd7, 1'b1, 1'b0);
      send(8'h2A, 4'd7, 1'b1, 1'b0);
      bitp(1'b1, BIT);
      drain("c2_drain");
      chk("c2_dones", dones - d0, 2);
      chk("c2_rxdata", {24'd0, RxData}, 32'h2A);

      // 3: glitch of 4 Ticks, then 0x3C
      d0 = dones;
      bitp(1'b0, 16);
      bitp(1'b1, 2*BIT);
      chk("c3_glitch_dones", dones - d0, 0);
      send(8'h3C, 4'd8, 1'b1, 1'b0);
      bitp(1'b1, BIT);
      drain("c3_drain");
      chk("c3_rxdata", {24'd0, RxData}, 32'h3C);

      // 4: 0xFF with low stop bit, line low 20 bits, then 0x81
      d0 = dones;
      send(8'hFF, 4'd8, 1'b0, 1'b0);
      bitp(1'b0, 20*BIT);
      chk("c4_break_dones", dones - d0, 1);
      chk("c4_break_ferr", {31'd0, FrameErr}, 32'h1);
      bitp(1'b1, 2*BIT);
      send(8'h81, 4'd8, 1'b1, 1'b0);
      bitp(1'b1, BIT);
      drain("c4_drain");
      chk("c4_dones", dones - d0, 2);
      chk("c4_rxdata", {24'd0, RxData}, 32'h81);
      chk("c4_frameerr", {31'd0, FrameErr}, 32'h0);

      // 5: RxEn dropped mid data bit 3 of 0x96
      d0 = dones;
      NBits = 4'd8;
      bitp(1'b0, BIT);
      for (int i = 0; i < 3; i++) bitp(v[i], BIT);
      bitp(v[3], BIT/2);
      RxEn = 1'b0;
      bitp(v[3], BIT/2);
      for (int i = 4; i < 8; i++) bitp(v[i], BIT);
      bitp(1'b1, 2*BIT);
      RxEn = 1'b1;
      chk("c5_abort_dones", dones - d0, 0);
      chk("c5_abort_rxdata", {24'd0, RxData}, 32'h81);
      send(8'h96, 4'd8, 1'b1, 1'b0);
      bitp(1'b1, BIT);
      drain("c5_drain");
      chk("c5_rxdata", {24'd0, RxData}, 32'h96);

      // 6: reset pulse during stop bit of 0x12
      d0 = dones;
      NBits = 4'd8;
      bitp(1'b0, BIT);
      for (int i = 0; i < 8; i++) bitp(1'(8'h12 >> i), BIT);
      bitp(1'b1, 8);
      Rst_n = 1'b0;
      exp_data = 8'h00;
      exp_ferr = 1'b0;
      wait_clk(2);
      Rst_n = 1'b1;
      bitp(1'b1, BIT - 10 + BIT);
      chk("c6_reset_dones", dones - d0, 0);
      chk("c6_reset_rxdata", {24'd0, RxData}, 32'h0);
      send(8'h34, 4'd8, 1'b1, 1'b0);
      bitp(1'b1, BIT);
      drain("c6_drain");
      chk("c6_rxdata", {24'd0, RxData}, 32'h34);

      // Random frames: widths, out-of-range NBits, framing errors, gaps,
      // NBits changed mid-frame.
      for (int k = 0; k < 30; k++) begin
         logic [3:0] nb;
         logic       sv;
         if ($urandom_range(4, 0) == 0)
            nb = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 9));
         else
            nb = 4'($urandom_range(NBITS_MAX, NBITS_MIN));
         sv = ($urandom_range(5, 0) != 0);
         send(8'($urandom), nb, sv, $urandom_range(1, 0) == 1);
         if (!sv) begin
            bitp(1'b0, BIT * $urandom_range(3, 0));
            bitp(1'b1, 2*BIT);
         end else begin
            bitp(1'b1, BIT * $urandom_range(2, 0));
         end
      end
      bitp(1'b1, BIT);
      drain("rand_drain");

      wait_clk(10);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
